branch_update_ctrl: RTL and testbench

BRANCH_UPDATE_CTRL -- requirements
Module: branch_update_ctrl

---
 rtl/branch_ctrl_pkg.sv | 30 +++
 rtl/branch_update_ctrl_if.sv | 36 +++
 rtl/branch_update_fifo.sv | 59 +++++
 rtl/branch_update_ctrl.sv | 133 +++++++++++++
 tb/tb_branch_update_ctrl.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the branch predictor update controller.
// Holds the FSM state encoding, default queue/squash sizing, the queued
// branch record layout and the fetch-redirect address helper.
package branch_ctrl_pkg;

  localparam int unsigned PC_W     = 32;
  localparam int unsigned TAKEN_W  = 1;
  localparam int unsigned TARGET_W = 32;
  localparam int unsigned ENTRY_W  = TAKEN_W + PC_W + TARGET_W;

  localparam int unsigned DEPTH_DEFAULT         = 4;
  localparam int unsigned SQUASH_CYCLES_DEFAULT = 3;

  localparam int unsigned STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;  // queue empty
  localparam logic [STATE_W-1:0] ST_DRAIN  = 2'd1;  // queue non-empty, updating predictor
  localparam logic [STATE_W-1:0] ST_SQUASH = 2'd2;  // redirect in progress, input blocked

  typedef struct packed {
    logic [PC_W-1:0]     pc;
    logic                taken;
    logic [TARGET_W-1:0] target;
  } branch_entry_t;

  // Correct fetch address for a mispredicted branch: target if taken, else fall-through.
  function automatic logic [PC_W-1:0] redirect_addr(input branch_entry_t e);
    return e.taken ? e.target : e.pc + PC_W'(4);
  endfunction

endpackage

// File: rtl/branch_update_ctrl_if.sv
// Bundle of execute-stage, predictor-update and fetch-redirect signals.
//   master : controller side (accepts resolved branches, drives predictor/redirect)
//   slave  : pipeline/predictor side
interface branch_update_ctrl_if;
  import branch_ctrl_pkg::*;

  logic                ex_valid;
  logic [PC_W-1:0]     ex_pc;
  logic                ex_taken;
  logic [TARGET_W-1:0] ex_target;
  logic                ex_ready;

  logic                bp_write;
  logic [PC_W-1:0]     bp_pc_write;
  logic                bp_branch_result;
  logic [TARGET_W-1:0] bp_branch_address;
  logic                bp_mispredict;

  logic                redirect_valid;
  logic [PC_W-1:0]     redirect_pc;
  logic                flush;
  logic                busy;

  modport master (
    input  ex_valid, ex_pc, ex_taken, ex_target, bp_mispredict,
    output ex_ready, bp_write, bp_pc_write, bp_branch_result, bp_branch_address,
    output redirect_valid, redirect_pc, flush, busy
  );

  modport slave (
    output ex_valid, ex_pc, ex_taken, ex_target, bp_mispredict,
    input  ex_ready, bp_write, bp_pc_write, bp_branch_result, bp_branch_address,
    input  redirect_valid, redirect_pc, flush, busy
  );

endinterface

// File: rtl/branch_update_fifo.sv
// Circular queue of resolved branches awaiting a predictor update.
// Ports: clock, reset (sync, active-high), push/din enqueue, pop dequeue,
// clear empties the queue (wins over push/pop), head is the oldest entry,
// full/empty/count report occupancy (count 0..DEPTH).
module branch_update_fifo
  import branch_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clear,
  input  branch_entry_t                din,
  output branch_entry_t                head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  branch_entry_t mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic do_push;
  logic do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by count.
  always_ff @(posedge clock) begin
    if (do_push && !clear && !reset) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/branch_update_ctrl.sv
// Drains resolved branches into the branch predictor one per cycle and, on
// a reported mispredict, issues a one-cycle registered fetch redirect/flush,
// empties the queue and blocks new branches for SQUASH_CYCLES cycles.
// Ports: clock, reset (sync, active-high), bus (branch_update_ctrl_if.master):
//   ex_*        resolved-branch handshake from execute
//   bp_*        predictor update (combinational from queue head), bp_mispredict back
//   redirect_*  registered fetch redirect, flush, busy status
module branch_update_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH         = DEPTH_DEFAULT,
  parameter int unsigned SQUASH_CYCLES = SQUASH_CYCLES_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  branch_update_ctrl_if.master bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SQ_W  = $clog2(SQUASH_CYCLES + 1);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_next;
  logic [SQ_W-1:0]    sq_cnt;
  logic [SQ_W-1:0]    sq_cnt_next;

  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  branch_entry_t    head;
  branch_entry_t    ex_entry;

  logic ready;
  logic push;
  logic pop;
  logic mispredict;

  logic            redirect_valid_q;
  logic            flush_q;
  logic [PC_W-1:0] redirect_pc_q;

  // Handshake and predictor-update qualification.
  assign ready      = !full && (state != ST_SQUASH);
  assign push       = bus.ex_valid && ready;
  assign pop        = !empty && (state != ST_SQUASH);
  assign mispredict = pop && bus.bp_mispredict;

  assign ex_entry = '{pc: bus.ex_pc, taken: bus.ex_taken, target: bus.ex_target};

  // A mispredict discards everything, including a same-cycle enqueue.
  branch_update_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .clear (mispredict),
    .din   (ex_entry),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Predictor data is zeroed whenever no update is presented.
  assign bus.ex_ready          = ready;
  assign bus.bp_write          = pop;
  assign bus.bp_pc_write       = pop ? head.pc : '0;
  assign bus.bp_branch_result  = pop ? head.taken : 1'b0;
  assign bus.bp_branch_address = pop ? head.target : '0;

  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.flush          = flush_q;
  assign bus.busy           = (state != ST_IDLE);

  // Next-state and squash down-counter.
  always_comb begin
    state_next  = state;
    sq_cnt_next = sq_cnt;
    case (state)
      ST_IDLE: begin
        if (push) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (mispredict) begin
          state_next  = ST_SQUASH;
          sq_cnt_next = SQ_W'(SQUASH_CYCLES);
        end else if (pop && !push && (count == CNT_W'(1))) begin
          state_next = ST_IDLE;
        end
      end
      ST_SQUASH: begin
        if (sq_cnt <= SQ_W'(1)) begin
          state_next  = ST_IDLE;
          sq_cnt_next = '0;
        end else begin
          sq_cnt_next = sq_cnt - SQ_W'(1);
        end
      end
      default: begin
        state_next  = ST_IDLE;
        sq_cnt_next = '0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= ST_IDLE;
      sq_cnt <= '0;
    end else begin
      state  <= state_next;
      sq_cnt <= sq_cnt_next;
    end
  end

  // Registered redirect; redirect_pc holds its last value between redirects.
  always_ff @(posedge clock) begin
    if (reset) begin
      redirect_valid_q <= 1'b0;
      flush_q          <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      redirect_valid_q <= mispredict;
      flush_q          <= mispredict;
      if (mispredict) redirect_pc_q <= redirect_addr(head);
    end
  end

endmodule

// File: tb/tb_branch_update_ctrl.sv
// Self-checking bench for branch_update_ctrl: a per-cycle vector table plus
// hand sequences for continuous streaming and queue-full behaviour.
module tb_branch_update_ctrl;
  import branch_ctrl_pkg::*;

  logic clock;
  logic reset;
  int   errors;
  int   checks;

  branch_update_ctrl_if bus ();

  branch_update_ctrl #(
    .DEPTH         (4),
    .SQUASH_CYCLES (3)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Standalone queue instance to reach the full condition directly.
  logic          f_push;
  logic          f_pop;
  logic          f_clear;
  branch_entry_t f_din;
  branch_entry_t f_head;
  logic          f_full;
  logic          f_empty;
  logic [2:0]    f_count;

  branch_update_fifo #(
    .DEPTH (4)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (f_push),
    .pop   (f_pop),
    .clear (f_clear),
    .din   (f_din),
    .head  (f_head),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        ev;
    logic [31:0] pc;
    logic        tk;
    logic [31:0] tg;
    logic        mp;
    logic        rdy;
    logic        bw;
    logic [31:0] bpc;
    logic        bres;
    logic [31:0] baddr;
    logic        rv;
    logic [31:0] rpc;
    logic        fl;
    logic        bsy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(
    input logic rst, input logic ev, input logic [31:0] pc, input logic tk,
    input logic [31:0] tg, input logic mp, input logic rdy, input logic bw,
    input logic [31:0] bpc, input logic bres, input logic [31:0] baddr,
    input logic rv, input logic [31:0] rpc, input logic fl, input logic bsy);
    vec_t r;
    r.rst = rst; r.ev = ev; r.pc = pc; r.tk = tk; r.tg = tg; r.mp = mp;
    r.rdy = rdy; r.bw = bw; r.bpc = bpc; r.bres = bres; r.baddr = baddr;
    r.rv = rv; r.rpc = rpc; r.fl = fl; r.bsy = bsy;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ev, input logic [31:0] pc, input logic tk,
                       input logic [31:0] tg, input logic mp);
    bus.ex_valid      = ev;
    bus.ex_pc         = pc;
    bus.ex_taken      = tk;
    bus.ex_target     = tg;
    bus.bp_mispredict = mp;
  endtask

  initial begin
    branch_entry_t exp_q[$];
    branch_entry_t e;
    errors = 0;
    checks = 0;
    f_push = 1'b0; f_pop = 1'b0; f_clear = 1'b0; f_din = '0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clock);

    // rst ev pc tk tg mp | rdy bw bpc bres baddr | rv rpc fl busy
    tbl.push_back(v(0,0,32'h0,0,32'h0,0,      1,0,32'h0,0,32'h0,        0,32'h0,0,0));
    // three in-order updates, no redirect
    tbl.push_back(v(0,1,32'h1000,1,32'h2000,0, 1,0,32'h0,0,32'h0,       0,32'h0,0,0));
    tbl.push_back(v(0,1,32'h1010,0,32'h3000,0, 1,1,32'h1000,1,32'h2000, 0,32'h0,0,1));
    tbl.push_back(v(0,1,32'h1020,1,32'h4000,0, 1,1,32'h1010,0,32'h3000, 0,32'h0,0,1));
    tbl.push_back(v(0,0,32'h0,0,32'h0,0,      1,1,32'h1020,1,32'h4000,  0,32'h0,0,1));
    tbl.push_back(v(0,0,32'h0,0,32'h0,0,      1,0,32'h0,0,32'h0,        0,32'h0,0,0));
    // taken mispredict, same-cycle enqueue dropped, input ignored in squash
    tbl.push_back(v(0,1,32'h100,1,32'h200,0,  1,0,32'h0,0,32'h0,        0,32'h0,0,0));
    tbl.push_back(v(0,1,32'h500,0,32'h0,1,    1,1,32'h100,1,32'h200,    0,32'h0,0,1));
    tbl.push_back(v(0,1,32'h600,1,32'h700,0,  0,0,32'h0,0,32'h0,        1,32'h200,1,1));
    tbl.push_back(v(0,1,32'h600,1,32'h700,0,  0,0,32'h0,0,32'h0,        0,32'h200,0,1));
    tbl.push_back(v(0,1,32'h600,1,32'h700,1,  0,0,32'h0,0,32'h0,        0,32'h200,0,1));
    tbl.push_back(v(0,0,32'h0,0,32'h0,1,      1,0,32'h0,0,32'h0,        0,32'h200,0,0));
    tbl.push_back(v(0,0,32'h0,0,32'h0,0,      1,0,32'h0,0,32'h0,        0,32'h200,0,0));
    // not-taken mispredict -> pc + 4
    tbl.push_back(v(0,1,32'h100,0,32'h900,0,  1,0,32'h0,0,32'h0,        0,32'h200,0,0));
    tbl.push_back(v(0,0,32'h0,0,32'h0,1,      1,1,32'h100,0,32'h900,    0,32'h200,0,1));
    tbl.push_back(v(0,0,32'h0,0,32'h0,0,      0,0,32'h0,0,32'h0,        1,32'h104,1,1));
    tbl.push_back(v(0,0,32'h0,0,32'h0,0,      0,0,32'h0,0,32'h0,        0,32'h104,0,1));
    tbl.push_back(v(0,0,32'h0,0,32'h0,0,      0,0,32'h0,0,32'h0,        0,32'h104,0,1));
    tbl.push_back(v(0,0,32'h0,0,32'h0,0,      1,0,32'h0,0,32'h0,        0,32'h104,0,0));
    // fall-through address wraps modulo 2^32
    tbl.push_back(v(0,1,32'hFFFF_FFFC,0,32'h40,0, 1,0,32'h0,0,32'h0,    0,32'h104,0,0));
    tbl.push_back(v(0,0,32'h0,0,32'h0,1,      1,1,32'hFFFF_FFFC,0,32'h40, 0,32'h104,0,1));
    tbl.push_back(v(0,0,32'h0,0,32'h0,0,      0,0,32'h0,0,32'h0,        1,32'h0,1,1));
    tbl.push_back(v(0,0,32'h0,0,32'h0,0,      0,0,32'h0,0,32'h0,        0,32'h0,0,1));
    tbl.push_back(v(0,0,32'h0,0,32'h0,0,      0,0,32'h0,0,32'h0,        0,32'h0,0,1));
    tbl.push_back(v(0,0,32'h0,0,32'h0,0,      1,0,32'h0,0,32'h0,        0,32'h0,0,0));
    // reset in the second squash cycle
    tbl.push_back(v(0,1,32'h7FC,1,32'hABC0,0, 1,0,32'h0,0,32'h0,        0,32'h0,0,0));
    tbl.push_back(v(0,0,32'h0,0,32'h0,1,      1,1,32'h7FC,1,32'hABC0,   0,32'h0,0,1));
    tbl.push_back(v(0,0,32'h0,0,32'h0,0,      0,0,32'h0,0,32'h0,        1,32'hABC0,1,1));
    tbl.push_back(v(1,0,32'h0,0,32'h0,0,      0,0,32'h0,0,32'h0,        0,32'hABC0,0,1));
    tbl.push_back(v(0,0,32'h0,0,32'h0,0,      1,0,32'h0,0,32'h0,        0,32'h0,0,0));
    // reset dominates a same-cycle enqueue and mispredict
    tbl.push_back(v(0,1,32'h800,1,32'h900,0,  1,0,32'h0,0,32'h0,        0,32'h0,0,0));
    tbl.push_back(v(1,1,32'h810,0,32'h0,1,    1,1,32'h800,1,32'h900,    0,32'h0,0,1));
    tbl.push_back(v(0,0,32'h0,0,32'h0,0,      1,0,32'h0,0,32'h0,        0,32'h0,0,0));
    tbl.push_back(v(0,0,32'h0,0,32'h0,0,      1,0,32'h0,0,32'h0,        0,32'h0,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clock);
      reset = tbl[i].rst;
      drive(tbl[i].ev, tbl[i].pc, tbl[i].tk, tbl[i].tg, tbl[i].mp);
      #1;
      chk($sformatf("row%0d ex_ready", i),          32'(bus.ex_ready),         32'(tbl[i].rdy));
      chk($sformatf("row%0d bp_write", i),          32'(bus.bp_write),         32'(tbl[i].bw));
      chk($sformatf("row%0d bp_pc_write", i),       bus.bp_pc_write,           tbl[i].bpc);
      chk($sformatf("row%0d bp_branch_result", i),  32'(bus.bp_branch_result), 32'(tbl[i].bres));
      chk($sformatf("row%0d bp_branch_address", i), bus.bp_branch_address,     tbl[i].baddr);
      chk($sformatf("row%0d redirect_valid", i),    32'(bus.redirect_valid),   32'(tbl[i].rv));
      chk($sformatf("row%0d redirect_pc", i),       bus.redirect_pc,           tbl[i].rpc);
      chk($sformatf("row%0d flush", i),             32'(bus.flush),            32'(tbl[i].fl));
      chk($sformatf("row%0d busy", i),              32'(bus.busy),             32'(tbl[i].bsy));
    end

    // Back-to-back enqueue for 10 cycles: pointers wrap, order preserved.
    for (int i = 0; i <= 10; i++) begin
      @(negedge clock);
      reset = 1'b0;
      e.pc     = 32'h2000 + 32'(i * 16);
      e.taken  = 1'(i % 2);
      e.target = 32'h8000 + 32'(i);
      drive(1'(i < 10), e.pc, e.taken, e.target, 1'b0);
      #1;
      chk($sformatf("stream%0d ex_ready", i), 32'(bus.ex_ready), 32'd1);
      if (exp_q.size() > 0) begin
        branch_entry_t h;
        h = exp_q.pop_front();
        chk($sformatf("stream%0d bp_write", i),  32'(bus.bp_write),         32'd1);
        chk($sformatf("stream%0d bp_pc", i),     bus.bp_pc_write,            h.pc);
        chk($sformatf("stream%0d bp_result", i), 32'(bus.bp_branch_result), 32'(h.taken));
        chk($sformatf("stream%0d bp_addr", i),   bus.bp_branch_address,      h.target);
      end else begin
        chk($sformatf("stream%0d bp_write", i),  32'(bus.bp_write),         32'd0);
      end
      if (i < 10) exp_q.push_back(e);
    end
    @(negedge clock);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    chk("stream_end busy", 32'(bus.busy), 32'd0);
    chk("stream_end bp_write", 32'(bus.bp_write), 32'd0);

    // Queue fill with no pops: full at 4, fifth push rejected.
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      f_push = 1'b1;
      f_din  = '{pc: 32'hA0 + 32'(i), taken: 1'b0, target: 32'h0};
      #1;
      chk($sformatf("fill%0d count", i), 32'(f_count), 32'((i < 4) ? i : 4));
      chk($sformatf("fill%0d full", i),  32'(f_full),  32'(i == 4));
    end
    @(negedge clock);
    f_push = 1'b0;
    f_pop  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("drain%0d head_pc", i), f_head.pc, 32'hA0 + 32'(i));
      @(negedge clock);
    end
    f_pop = 1'b0;
    #1;
    chk("drain empty", 32'(f_empty), 32'd1);
    chk("drain count", 32'(f_count), 32'd0);

    // Clear empties a partially filled queue.
    @(negedge clock);
    f_push = 1'b1;
    f_din  = '{pc: 32'hB0, taken: 1'b1, target: 32'hC0};
    @(negedge clock);
    f_push  = 1'b0;
    f_clear = 1'b1;
    #1;
    chk("clear pre count", 32'(f_count), 32'd1);
    @(negedge clock);
    f_clear = 1'b0;
    #1;
    chk("clear empty", 32'(f_empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
